pwm_duty_seq: RTL

PWM_DUTY_SEQ -- requirements
Module: pwm_duty_seq

---
 rtl/pwm_duty_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pwm_duty_seq.sv
// pwm_duty_seq -- duty-cycle sequencer for a 4-channel PWM.
//
// Steps through a small table of 4-channel compare values. Each entry is put
// on cr_o for (rep_i+1) PWM periods (counted in ovf_i pulses), then the next
// entry is loaded. It can run once (ending in DONE with a done_o pulse) or
// loop back to entry 0.
//
// Ports:
//   apb4_pclk     clock, rising edge
//   apb4_presetn  asynchronous active-low reset
//   en_i          sequencer enable (level); low aborts to IDLE
//   loop_i        1 = wrap to entry 0 after the last entry, 0 = one-shot
//   len_i         index of last table entry used (entries 0..len_i)
//   rep_i         extra periods each entry is held (sampled in LOAD)
//   wr_en_i       table write strobe
//   wr_idx_i      table write index
//   wr_data_i     entry data, channel k at [k*CRX_WIDTH +: CRX_WIDTH]
//   ovf_i         one-cycle period-end pulse from the PWM counter
//   cr_o          current duty values for channels 0..3
//   cr_upd_o      one-cycle pulse in the cycle cr_o shows a new entry
//   idx_o         index of the entry currently on cr_o (0 in IDLE)
//   busy_o        high in LOAD or RUN
//   done_o        one-cycle pulse on one-shot completion
module pwm_duty_seq #(
    parameter int CRX_WIDTH = 16,
    parameter int DEPTH     = 8,
    localparam int IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   apb4_pclk,
    input  logic                   apb4_presetn,
    input  logic                   en_i,
    input  logic                   loop_i,
    input  logic [IW-1:0]          len_i,
    input  logic [7:0]             rep_i,
    input  logic                   wr_en_i,
    input  logic [IW-1:0]          wr_idx_i,
    input  logic [4*CRX_WIDTH-1:0] wr_data_i,
    input  logic                   ovf_i,
    output logic [4*CRX_WIDTH-1:0] cr_o,
    output logic                   cr_upd_o,
    output logic [IW-1:0]          idx_o,
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t                            r_state, w_state_nxt;
    logic [DEPTH-1:0][4*CRX_WIDTH-1:0] r_table;
    logic [IW-1:0]                     r_idx, w_idx_nxt;
    logic [IW-1:0]                     r_idx_o;
    logic [7:0]                        r_hold, w_hold_nxt;
    logic [4*CRX_WIDTH-1:0]            r_cr;
    logic                              r_upd, r_done;
    logic                              w_load, w_done_set, w_last;

    // >= so that lowering len_i below the running index still ends the pass.
    assign w_last = (r_idx >= len_i);

    always_ff @(posedge apb4_pclk or negedge apb4_presetn) begin
        if (!apb4_presetn) r_state <= S_IDLE;
        else               r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_hold_nxt  = r_hold;
        w_load      = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_idx_nxt = '0;
                if (en_i) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (!en_i) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_load      = 1'b1;
                    w_hold_nxt  = rep_i;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!en_i) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end else if (ovf_i) begin
                    if (r_hold != 8'd0) begin
                        w_hold_nxt = r_hold - 8'd1;
                    end else if (!w_last) begin
                        w_idx_nxt   = r_idx + IW'(1);
                        w_state_nxt = S_LOAD;
                    end else if (loop_i) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_done_set  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!en_i) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Table write and LOAD read share an edge; the read sees the pre-write
    // contents, so a same-cycle write only affects later loads.
    always_ff @(posedge apb4_pclk or negedge apb4_presetn) begin
        if (!apb4_presetn) r_table <= '0;
        else if (wr_en_i)  r_table[wr_idx_i] <= wr_data_i;
    end

    always_ff @(posedge apb4_pclk or negedge apb4_presetn) begin
        if (!apb4_presetn) begin
            r_idx   <= '0;
            r_idx_o <= '0;
            r_hold  <= '0;
            r_cr    <= '0;
            r_upd   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_hold <= w_hold_nxt;
            r_upd  <= w_load;
            r_done <= w_done_set;
            if (w_load) begin
                r_cr    <= r_table[r_idx];
                r_idx_o <= r_idx;
            end else if (w_state_nxt == S_IDLE) begin
                r_idx_o <= '0;
            end
        end
    end

    assign cr_o     = r_cr;
    assign cr_upd_o = r_upd;
    assign idx_o    = r_idx_o;
    assign done_o   = r_done;
    assign busy_o   = (r_state == S_LOAD) || (r_state == S_RUN);

endmodule
